// File: rtl/seq_stream_checker.sv
// Checks that accepted stream words form a modulo-2^W sequence with a fixed step.
// Locks on the first word, resynchronises on every mismatch and goes sticky-FAULT after MAX_MISS misses in a row.
module seq_stream_checker #(
    parameter int W        = 4,
    parameter int STEP     = 1,
    parameter int CNT_W    = 16,
    parameter int MAX_MISS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     i_data,
    input  logic             i_en,
    input  logic             i_clear,
    output logic [W-1:0]     o_expected,
    output logic [W-1:0]     o_last_data,
    output logic [CNT_W-1:0] o_rx_count,
    output logic [CNT_W-1:0] o_err_count,
    output logic             o_mismatch,
    output logic             o_locked,
    output logic             o_fault
);

    localparam int MISS_W = (MAX_MISS < 1) ? 1 : $clog2(MAX_MISS + 1);
    localparam logic [W-1:0]      STEP_W   = W'(STEP);
    localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(MAX_MISS);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'b00,
        ST_LOCKED   = 2'b01,
        ST_FAULT    = 2'b10
    } state_t;

    state_t             r_state, w_state_next;
    logic [W-1:0]       r_expected, w_expected_next;
    logic [W-1:0]       r_last_data, w_last_data_next;
    logic [CNT_W-1:0]   r_rx_count, w_rx_count_next;
    logic [CNT_W-1:0]   r_err_count, w_err_count_next;
    logic               r_mismatch, w_mismatch_next;
    logic [MISS_W-1:0]  r_miss_run, w_miss_run_next;

    logic               w_word_bad;
    logic [MISS_W-1:0]  w_miss_inc;
    logic [CNT_W-1:0]   w_rx_inc;
    logic [CNT_W-1:0]   w_err_inc;

    // Only meaningful once a reference word exists (LOCKED or FAULT).
    assign w_word_bad = (r_state != ST_UNLOCKED) && (i_data != r_expected);
    assign w_miss_inc = (r_miss_run == MISS_MAX) ? r_miss_run : r_miss_run + MISS_W'(1);
    assign w_rx_inc   = (r_rx_count  == '1) ? r_rx_count  : r_rx_count  + CNT_W'(1);
    assign w_err_inc  = (r_err_count == '1) ? r_err_count : r_err_count + CNT_W'(1);

    always_comb begin
        w_state_next     = r_state;
        w_expected_next  = r_expected;
        w_last_data_next = r_last_data;
        w_rx_count_next  = r_rx_count;
        w_err_count_next = r_err_count;
        w_mismatch_next  = 1'b0;
        w_miss_run_next  = r_miss_run;

        if (i_clear) begin
            w_state_next     = ST_UNLOCKED;
            w_rx_count_next  = '0;
            w_err_count_next = '0;
            w_miss_run_next  = '0;
        end else if (i_en) begin
            w_last_data_next = i_data;
            w_expected_next  = i_data + STEP_W;
            w_rx_count_next  = w_rx_inc;
            case (r_state)
                ST_UNLOCKED: begin
                    w_state_next    = ST_LOCKED;
                    w_miss_run_next = '0;
                end
                default: begin
                    if (w_word_bad) begin
                        w_err_count_next = w_err_inc;
                        w_mismatch_next  = 1'b1;
                        w_miss_run_next  = w_miss_inc;
                        if (w_miss_inc == MISS_MAX)
                            w_state_next = ST_FAULT;
                    end else begin
                        w_miss_run_next = '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_UNLOCKED;
            r_expected  <= '0;
            r_last_data <= '0;
            r_rx_count  <= '0;
            r_err_count <= '0;
            r_mismatch  <= 1'b0;
            r_miss_run  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_expected  <= w_expected_next;
            r_last_data <= w_last_data_next;
            r_rx_count  <= w_rx_count_next;
            r_err_count <= w_err_count_next;
            r_mismatch  <= w_mismatch_next;
            r_miss_run  <= w_miss_run_next;
        end
    end

    assign o_expected  = r_expected;
    assign o_last_data = r_last_data;
    assign o_rx_count  = r_rx_count;
    assign o_err_count = r_err_count;
    assign o_mismatch  = r_mismatch;
    assign o_locked    = (r_state == ST_LOCKED);
    assign o_fault     = (r_state == ST_FAULT);

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst && !i_clear && i_en && w_word_bad)
            $display("seq_stream_checker: word out of sequence, got %h expected %h", i_data, r_expected);
    end
`endif

endmodule
